// File: rtl/pong_game_ctrl_if.sv
// Physics-engine link for the pong controller: step drive (ball/paddles) out,
// step result (score/ball/paddles) back.
interface pong_game_ctrl_if;
  logic [31:0] pp_ball_pos;
  logic [15:0] pp_ball_vel;
  logic [31:0] pp_left_paddle;
  logic [31:0] pp_right_paddle;
  logic [1:0]  pp_score;
  logic [31:0] pp_ball_pos_in;
  logic [15:0] pp_ball_vel_in;
  logic [31:0] pp_left_paddle_in;
  logic [31:0] pp_right_paddle_in;

  // Handshake: the controller presents drive values from the cycle after LOAD
  // and holds them until the next LOAD; the physics side must present a valid
  // result exactly STEP_LATENCY cycles later, when COMMIT samples it once.
  modport master (
    output pp_ball_pos, pp_ball_vel, pp_left_paddle, pp_right_paddle,
    input  pp_score, pp_ball_pos_in, pp_ball_vel_in, pp_left_paddle_in,
           pp_right_paddle_in
  );

  modport slave (
    input  pp_ball_pos, pp_ball_vel, pp_left_paddle, pp_right_paddle,
    output pp_score, pp_ball_pos_in, pp_ball_vel_in, pp_left_paddle_in,
           pp_right_paddle_in
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve timing, per-frame physics step sequencing,
// score keeping and frame-overrun detection.
module pong_game_ctrl #(
  parameter int               STEP_LATENCY = 2,
  parameter int               WIN_SCORE    = 7,
  parameter int               SERVE_DELAY  = 60,
  parameter logic signed [7:0] SERVE_VX    = 8'sd2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic [31:0]            dimensions,
  input  logic [31:0]            left_paddle_in,
  input  logic [31:0]            right_paddle_in,
  pong_game_ctrl_if.master       pp,
  output logic [31:0]            ball_pos,
  output logic [3:0]             left_score,
  output logic [3:0]             right_score,
  output logic [2:0]             state,
  output logic                   game_over,
  output logic                   frame_overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    WAIT_TICK = 3'd2,
    LOAD      = 3'd3,
    STEP      = 3'd4,
    COMMIT    = 3'd5,
    OVER      = 3'd6
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'((SERVE_DELAY == 0) ? 0 : SERVE_DELAY - 1);
  localparam logic [3:0] STEP_LAST  = 4'(STEP_LATENCY - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [7:0]  serve_cnt;
  logic [3:0]  step_cnt;
  logic [31:0] ball_pos_q;
  logic [15:0] ball_vel_q;
  logic        enter_serve;
  logic        serve_right;
  logic [3:0]  left_inc, right_inc;
  logic [15:0] half_w, half_h;

  assign half_w    = dimensions[31:16] >> 1;
  assign half_h    = dimensions[15:0] >> 1;
  assign left_inc  = (left_score == 4'hF) ? 4'hF : left_score + 4'd1;
  assign right_inc = (right_score == 4'hF) ? 4'hF : right_score + 4'd1;

  always_comb begin
    state_d     = state_q;
    enter_serve = 1'b0;
    serve_right = 1'b1;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d     = SERVE;
          enter_serve = 1'b1;
        end
      end
      SERVE: begin
        if (SERVE_DELAY == 0 || (frame_tick && serve_cnt == SERVE_LAST))
          state_d = WAIT_TICK;
      end
      WAIT_TICK: if (frame_tick) state_d = LOAD;
      LOAD:      state_d = STEP;
      STEP:      if (step_cnt == STEP_LAST) state_d = COMMIT;
      COMMIT: begin
        case (pp.pp_score)
          2'b01: begin
            // Right conceded: next serve heads right.
            state_d     = (left_inc == WIN) ? OVER : SERVE;
            enter_serve = (left_inc != WIN);
            serve_right = 1'b1;
          end
          2'b10: begin
            state_d     = (right_inc == WIN) ? OVER : SERVE;
            enter_serve = (right_inc != WIN);
            serve_right = 1'b0;
          end
          default: state_d = WAIT_TICK;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      serve_cnt          <= '0;
      step_cnt           <= '0;
      ball_pos_q         <= '0;
      ball_vel_q         <= '0;
      left_score         <= '0;
      right_score        <= '0;
      frame_overrun      <= 1'b0;
      pp.pp_ball_pos     <= '0;
      pp.pp_ball_vel     <= '0;
      pp.pp_left_paddle  <= '0;
      pp.pp_right_paddle <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            left_score    <= '0;
            right_score   <= '0;
            frame_overrun <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick)
            serve_cnt <= (state_d == WAIT_TICK) ? 8'd0 : serve_cnt + 8'd1;
        end
        LOAD: begin
          pp.pp_ball_pos     <= ball_pos_q;
          pp.pp_ball_vel     <= ball_vel_q;
          pp.pp_left_paddle  <= left_paddle_in;
          pp.pp_right_paddle <= right_paddle_in;
          step_cnt           <= '0;
        end
        STEP: step_cnt <= step_cnt + 4'd1;
        COMMIT: begin
          case (pp.pp_score)
            2'b01:   left_score  <= left_inc;
            2'b10:   right_score <= right_inc;
            default: begin
              ball_pos_q <= pp.pp_ball_pos_in;
              ball_vel_q <= pp.pp_ball_vel_in;
            end
          endcase
        end
        default: ;
      endcase
      if (enter_serve) begin
        ball_pos_q <= {half_w, half_h};
        ball_vel_q <= {serve_right ? SERVE_VX : 8'(-SERVE_VX), 8'd0};
        serve_cnt  <= '0;
      end
      // Ticks arriving mid-step are dropped, not queued.
      if (frame_tick && (state_q == LOAD || state_q == STEP || state_q == COMMIT))
        frame_overrun <= 1'b1;
    end
  end

  assign ball_pos  = ball_pos_q;
  assign state     = state_q;
  assign game_over = (state_q == OVER);

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter STEP_LATENCY, default 2, giving the cycles the physics datapath needs from a stable input to a valid output (legal range 1..15).
REQ-002 SHALL have parameter WIN_SCORE, default 7, giving the points that end a match (legal range 1..15).
REQ-003 SHALL have parameter SERVE_DELAY, default 60, giving the frame ticks the ball is held at centre before each serve (legal range 0..255).
REQ-004 SHALL have parameter SERVE_VX, default 8'sd2, giving the signed serve x-velocity magnitude; serve y-velocity is 0.
REQ-005 SHALL have ports: clk in 1, system clock; rst in 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports: start in 1, one-cycle pulse that begins a match; frame_tick in 1, one-cycle pulse per video frame.
REQ-007 SHALL have ports: dimensions in 32, {width[31:16], height[15:0]}; left_paddle_in in 32, current left paddle position; right_paddle_in in 32, current right paddle position.
REQ-008 SHALL have physics-drive ports: pp_ball_pos out 32; pp_ball_vel out 16, {vx[15:8], vy[7:0]} two's complement; pp_left_paddle out 32; pp_right_paddle out 32.
REQ-009 SHALL have physics-result ports: pp_score in 2; pp_ball_pos_in in 32; pp_ball_vel_in in 16; pp_left_paddle_in in 32; pp_right_paddle_in in 32.
REQ-010 SHALL have status ports: ball_pos out 32, committed ball position; left_score out 4; right_score out 4; state out 3; game_over out 1; frame_overrun out 1, sticky.

Function
REQ-011 SHALL implement the following states: IDLE=0, SERVE=1, WAIT_TICK=2, LOAD=3, STEP=4, COMMIT=5, OVER=6; the state output SHALL show the current encoding.
REQ-012 In IDLE or OVER, a start pulse SHALL clear both scores and go to SERVE; start SHALL be ignored in every other state.
REQ-013 On entering SERVE, the block SHALL set the committed ball to {width>>1, height>>1} and the committed velocity to {±SERVE_VX, 8'd0}.
REQ-014 The first serve of a match SHALL be +SERVE_VX (toward the right player); each later serve SHALL go toward the player who just conceded.
REQ-015 SERVE SHALL count frame ticks and go to WAIT_TICK on the SERVE_DELAY-th tick, or on the next cycle if SERVE_DELAY=0.
REQ-016 In WAIT_TICK, frame_tick SHALL cause a move to LOAD.
REQ-017 LOAD SHALL register pp_ball_pos/pp_ball_vel from the committed ball state and pp_left_paddle/pp_right_paddle from left_paddle_in/right_paddle_in, then go to STEP.
REQ-018 pp_* outputs SHALL hold stable from the cycle after LOAD until the next LOAD.
REQ-019 STEP SHALL last exactly STEP_LATENCY cycles (cycle counter), then go to COMMIT.
REQ-020 COMMIT SHALL sample pp_score and the pp_*_in inputs in a single cycle.
REQ-021 In COMMIT, pp_score=2'b00 or 2'b11 SHALL mean no score: the block SHALL commit pp_ball_pos_in and pp_ball_vel_in and go to WAIT_TICK.
REQ-022 In COMMIT, pp_score=2'b01 SHALL increment left_score (right conceded) and pp_score=2'b10 SHALL increment right_score (left conceded); ball results SHALL be discarded.
REQ-023 After a score, the block SHALL go to OVER if the incremented score equals WIN_SCORE, else to SERVE.
REQ-024 Timing: with frame_tick high in cycle t during WAIT_TICK, LOAD=t+1, pp_* valid t+2, COMMIT=t+2+STEP_LATENCY, and ball_pos updated and visible at t+3+STEP_LATENCY.
REQ-025 A frame_tick in LOAD, STEP or COMMIT SHALL be dropped (no queuing) and SHALL set frame_overrun, which clears only on rst or start.
REQ-026 frame_tick SHALL be ignored in IDLE and OVER; in SERVE it SHALL only advance the serve counter.
REQ-027 game_over SHALL be 1 exactly while state=OVER; scores SHALL saturate at 15 and never wrap.
REQ-028 ball_pos SHALL change only on entering SERVE or on a no-score COMMIT.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, all pp_* outputs=0, ball_pos=0, scores=0, game_over=0, frame_overrun=0, all counters=0, serve direction=+.
REQ-030 A reset during any state, including mid-STEP, SHALL abandon the step with no score or ball commit; after release the block SHALL wait for start.

Verification
REQ-031 dimensions=0x0280_01E0, start pulse, SERVE_DELAY=60 -> ball_pos=0x0140_00F0, vel=0x0200; WAIT_TICK after 60th tick.
REQ-032 WAIT_TICK, tick at t, pp_score=0, pp_ball_pos_in=0x0142_00F1 -> LOAD t+1, COMMIT t+4 (L=2), ball_pos=0x0142_00F1 at t+5.
REQ-033 pp_score=2'b01 at COMMIT with left_score=6, WIN_SCORE=7 -> left_score=7, state=OVER, game_over=1; start -> scores 0, SERVE.
REQ-034 pp_score=2'b10 -> right_score+1, SERVE, next serve vel vx=-2 (0xFE00); pp_score=2'b11 -> no score change.
REQ-035 frame_tick during STEP -> frame_overrun=1 sticky, tick dropped, no extra LOAD; rst asserted mid-STEP -> all outputs 0 immediately, state=IDLE.
